// File: rtl/fetch_decode.sv
// fetch_decode
//   Multi-cycle fetch/decode sequencer for an RV32 subset: R-type ALU,
//   I-type ALU, LUI and stores. It holds the PC and fetches one word at a
//   time over a valid/ready instruction-memory handshake. It decodes the
//   word into register/opcode/function fields and a sign-extended immediate,
//   then issues one-cycle register-write and store strobes. Any other
//   encoding parks the sequencer in HALT until the next reset.
//
//   Parameters
//     RESET_PC          PC value loaded by reset
//   Ports
//     clock             system clock, rising edge
//     reset             synchronous, active-high
//     imem_req          fetch request valid (FETCH only)
//     imem_addr         fetch address (current PC)
//     imem_ready        imem_rdata valid; completes the request
//     imem_rdata        instruction word
//     pc                address of the instruction being decoded/executed
//     rd/rs1/rs2        register fields
//     opcode/func3/func7 opcode and function fields
//     imm               decoded immediate
//     reg_write         register write strobe (EXECUTE only)
//     mem_write_enable  unshifted byte-lane mask (EXECUTE only)
//     store_enable      store strobe (EXECUTE only)
//     illegal           sticky, set on entering HALT
module fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [6:0]  opcode,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic [31:0] imm,
   output logic        reg_write,
   output logic [3:0]  mem_write_enable,
   output logic        store_enable,
   output logic        illegal
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_HALT
   } state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic        rw_q;
   logic        st_q;
   logic [3:0]  mask_q;
   logic        ill_q;

   // Decode of the latched word. Fields come straight from the instruction
   // register, so they stay put from DECODE until the next fetch completes,
   // and they read as zero after reset (ir cleared).
   logic        is_r, is_i, is_lui, is_store;
   logic        store_f3_ok;
   logic        legal;
   logic        wr_en_d;
   logic [3:0]  mask_d;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign func3  = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign func7  = ir_q[31:25];

   assign is_r     = (opcode == OP_R);
   assign is_i     = (opcode == OP_I);
   assign is_lui   = (opcode == OP_LUI);
   assign is_store = (opcode == OP_STORE);

   // Only SB/SH/SW exist; func3 >= 3 is not a valid RV32 store.
   assign store_f3_ok = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);

   // The legal opcodes all end in 2'b11; the explicit compressed-encoding
   // check keeps the rule visible should the opcode list ever grow.
   assign legal = (ir_q[1:0] == 2'b11) &&
                  (is_r || is_i || is_lui || (is_store && store_f3_ok));

   assign wr_en_d = (is_r || is_i || is_lui) && (rd != 5'd0);

   always_comb begin
      imm = 32'd0;
      if (is_i)
         imm = {{20{ir_q[31]}}, ir_q[31:20]};
      else if (is_store)
         imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      else if (is_lui)
         imm = {ir_q[31:12], 12'd0};
   end

   always_comb begin
      mask_d = 4'b0000;
      case (func3)
         3'b000:  mask_d = 4'b0001;
         3'b001:  mask_d = 4'b0011;
         3'b010:  mask_d = 4'b1111;
         default: mask_d = 4'b0000;
      endcase
   end

   // Sequencer. Strobes default low each cycle, so they are high only in
   // the cycle following the DECODE->EXECUTE edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_FETCH;
         pc_q   <= RESET_PC;
         ir_q   <= 32'd0;
         rw_q   <= 1'b0;
         st_q   <= 1'b0;
         mask_q <= 4'b0000;
         ill_q  <= 1'b0;
      end else begin
         rw_q   <= 1'b0;
         st_q   <= 1'b0;
         mask_q <= 4'b0000;
         case (state)
            S_FETCH: begin
               if (imem_ready) begin
                  ir_q  <= imem_rdata;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (legal) begin
                  state <= S_EXECUTE;
                  rw_q  <= wr_en_d;
                  if (is_store) begin
                     st_q   <= 1'b1;
                     mask_q <= mask_d;
                  end
               end else begin
                  state <= S_HALT;
                  ill_q <= 1'b1;
               end
            end
            S_EXECUTE: begin
               pc_q  <= pc_q + 32'd4;
               state <= S_FETCH;
            end
            S_HALT: begin
               state <= S_HALT;
            end
         endcase
      end
   end

   // Reset masks the request and strobes in the very cycle it is asserted,
   // so a reset landing on EXECUTE never leaks a write into the datapath.
   assign imem_req         = (state == S_FETCH) && !reset;
   assign imem_addr        = pc_q;
   assign pc               = pc_q;
   assign reg_write        = rw_q & ~reset;
   assign store_enable     = st_q & ~reset;
   assign mem_write_enable = mask_q & {4{~reset}};
   assign illegal          = ill_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode. Two instances share all inputs: one resets to
// 32'h100, the other to 32'hFFFF_FFFC so PC wrap-around is exercised on
// every first instruction after reset. A transaction-level model builds the
// expected per-cycle outputs from each instruction's decode and its
// FETCH-wait / DECODE / EXECUTE / HALT timeline.
module tb_fetch_decode;

   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam logic [31:0] RPC_W = 32'hFFFF_FFFC;
   localparam logic [31:0] W_OFF = RPC_W - RPC;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'd0;

   logic        req_a, rw_a, st_a, ill_a;
   logic [31:0] addr_a, pc_a, imm_a;
   logic [4:0]  rd_a, rs1_a, rs2_a;
   logic [6:0]  op_a, f7_a;
   logic [2:0]  f3_a;
   logic [3:0]  mask_a;

   logic        req_w, rw_w, st_w, ill_w;
   logic [31:0] addr_w, pc_w, imm_w;
   logic [4:0]  rd_w, rs1_w, rs2_w;
   logic [6:0]  op_w, f7_w;
   logic [2:0]  f3_w;
   logic [3:0]  mask_w;

   fetch_decode #(.RESET_PC(RPC)) dut (
      .clock(clock), .reset(reset),
      .imem_req(req_a), .imem_addr(addr_a), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc(pc_a), .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a), .opcode(op_a), .func3(f3_a), .func7(f7_a),
      .imm(imm_a), .reg_write(rw_a), .mem_write_enable(mask_a), .store_enable(st_a), .illegal(ill_a)
   );

   fetch_decode #(.RESET_PC(RPC_W)) dut_w (
      .clock(clock), .reset(reset),
      .imem_req(req_w), .imem_addr(addr_w), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .pc(pc_w), .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .opcode(op_w), .func3(f3_w), .func7(f7_w),
      .imm(imm_w), .reg_write(rw_w), .mem_write_enable(mask_w), .store_enable(st_w), .illegal(ill_w)
   );

   always #5 clock = ~clock;

   // ---------------- model ----------------
   typedef struct packed {
      logic [4:0]  rd, rs1, rs2;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        legal, rw, st;
      logic [3:0]  mask;
   } dec_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d     = '0;
      d.rd  = w[11:7];
      d.rs1 = w[19:15];
      d.rs2 = w[24:20];
      d.op  = w[6:0];
      d.f3  = w[14:12];
      d.f7  = w[31:25];
      case (d.op)
         7'b0110011: d.legal = 1'b1;
         7'b0010011: begin d.legal = 1'b1; d.imm = 32'($signed(w[31:20])); end
         7'b0110111: begin d.legal = 1'b1; d.imm = w & 32'hFFFF_F000; end
         7'b0100011: begin
            d.imm   = 32'($signed({w[31:25], w[11:7]}));
            d.legal = (d.f3 <= 3'd2);
            d.st    = d.legal;
            // bytes stored = 2**func3, as a low-aligned lane mask
            if (d.st) d.mask = 4'((1 << (1 << d.f3)) - 1);
         end
         default: ;
      endcase
      d.rw = d.legal && !d.st && (d.rd != 5'd0);
      return d;
   endfunction

   logic [31:0] m_pc;
   dec_t        m_d;
   logic        m_ill;

   // expected outputs for the current cycle
   logic        chk_on = 1'b0;
   logic        e_full, e_req, e_strobe;
   logic [31:0] e_pc;
   dec_t        e_d;
   logic        e_ill;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (chk_on) begin
         chk("req",    {31'd0, req_a},  {31'd0, e_req});
         chk("req_w",  {31'd0, req_w},  {31'd0, e_req});
         chk("rw",     {31'd0, rw_a},   {31'd0, e_strobe & e_d.rw});
         chk("rw_w",   {31'd0, rw_w},   {31'd0, e_strobe & e_d.rw});
         chk("st",     {31'd0, st_a},   {31'd0, e_strobe & e_d.st});
         chk("st_w",   {31'd0, st_w},   {31'd0, e_strobe & e_d.st});
         chk("mask",   {28'd0, mask_a}, {28'd0, e_strobe ? e_d.mask : 4'd0});
         chk("mask_w", {28'd0, mask_w}, {28'd0, e_strobe ? e_d.mask : 4'd0});
         if (e_full) begin
            chk("pc",    pc_a, e_pc);
            chk("pc_w",  pc_w, e_pc + W_OFF);
            if (e_req) begin
               chk("addr",   addr_a, e_pc);
               chk("addr_w", addr_w, e_pc + W_OFF);
            end
            chk("rd",     {27'd0, rd_a},  {27'd0, e_d.rd});
            chk("rs1",    {27'd0, rs1_a}, {27'd0, e_d.rs1});
            chk("rs2",    {27'd0, rs2_a}, {27'd0, e_d.rs2});
            chk("opcode", {25'd0, op_a},  {25'd0, e_d.op});
            chk("func3",  {29'd0, f3_a},  {29'd0, e_d.f3});
            chk("func7",  {25'd0, f7_a},  {25'd0, e_d.f7});
            chk("imm",    imm_a, e_d.imm);
            chk("imm_w",  imm_w, e_d.imm);
            chk("illegal",   {31'd0, ill_a}, {31'd0, e_ill});
            chk("illegal_w", {31'd0, ill_w}, {31'd0, e_ill});
         end
      end
   end

   // ---------------- stimulus ----------------
   int          cnt_in = 0;
   int          rw_last = 0;
   logic        obs_rw, obs_st;
   logic [3:0]  obs_mask;

   // drive one cycle's inputs and expectations, then wait to the sample point
   task automatic cyc_in(input logic rst, input logic rdy, input logic [31:0] data,
                         input logic full, input logic req, input logic strobe);
      reset      = rst;
      imem_ready = rdy;
      imem_rdata = data;
      e_full     = full;
      e_req      = req;
      e_strobe   = strobe;
      e_pc       = m_pc;
      e_d        = m_d;
      e_ill      = m_ill;
      chk_on     = 1'b1;
      cnt_in++;
      @(negedge clock);
      if (rw_a) rw_last = cnt_in;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      m_pc  = RPC;
      m_d   = decode(32'd0);
      m_ill = 1'b0;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         cyc_in(1'b1, 1'b1, $urandom, i > 0, 1'b0, 1'b0);
         step();
         model_reset();
      end
   endtask

   // One instruction: `waits` stalled fetch cycles, then the accepted one,
   // DECODE, and either EXECUTE (optionally hit by reset) or a HALT stretch.
   task automatic do_instr(input logic [31:0] word, input int waits, input logic rst_exec);
      for (int i = 0; i <= waits; i++) begin
         cyc_in(1'b0, i == waits, (i == waits) ? word : $urandom, 1'b1, 1'b1, 1'b0);
         step();
      end
      m_d = decode(word);
      cyc_in(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
      step();
      if (!m_d.legal) begin
         m_ill = 1'b1;
         for (int i = 0; i < 5; i++) begin
            cyc_in(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0);
            step();
         end
         obs_rw = 1'b0; obs_st = 1'b0; obs_mask = 4'd0;
      end else begin
         cyc_in(rst_exec, 1'b1, $urandom, 1'b1, 1'b0, !rst_exec);
         obs_rw   = rw_a;
         obs_st   = st_a;
         obs_mask = mask_a;
         step();
         if (rst_exec) model_reset();
         else          m_pc = m_pc + 32'd4;
      end
   endtask

   int t0;

   initial begin
      @(posedge clock);
      #1;
      do_reset(3);

      // first cycle out of reset, hold ready low once
      cyc_in(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
      chk("lit_reset_req",  {31'd0, req_a}, 32'd1);
      chk("lit_reset_addr", addr_a, 32'h100);
      chk("lit_reset_ill",  {31'd0, ill_a}, 32'd0);
      chk("lit_reset_imm",  imm_a, 32'd0);
      step();

      // add x3,x1,x2
      do_instr(32'h0020_81B3, 0, 1'b0);
      chk("lit_add_rd",  {27'd0, rd_a},  32'd3);
      chk("lit_add_rs1", {27'd0, rs1_a}, 32'd1);
      chk("lit_add_rs2", {27'd0, rs2_a}, 32'd2);
      chk("lit_add_imm", imm_a, 32'd0);
      chk("lit_add_rw",  {31'd0, obs_rw}, 32'd1);
      chk("lit_next_addr", addr_a, 32'h104);
      chk("lit_wrap_addr", addr_w, 32'h0);

      // addi x1,x0,-1 with three stalled fetch cycles
      t0 = cnt_in + 1;
      do_instr(32'hFFF0_0093, 3, 1'b0);
      chk("lit_addi_imm", imm_a, 32'hFFFF_FFFF);
      chk("lit_addi_latency", 32'(rw_last - t0 + 1), 32'd6);

      // sw x1,-4(x2), then sb and sh variants
      do_instr(32'hFE11_2E23, 1, 1'b0);
      chk("lit_sw_imm",  imm_a, 32'hFFFF_FFFC);
      chk("lit_sw_mask", {28'd0, obs_mask}, 32'hF);
      chk("lit_sw_st",   {31'd0, obs_st}, 32'd1);
      chk("lit_sw_rw",   {31'd0, obs_rw}, 32'd0);
      do_instr(32'hFE11_0E23, 0, 1'b0);
      chk("lit_sb_mask", {28'd0, obs_mask}, 32'h1);
      do_instr(32'hFE11_1E23, 2, 1'b0);
      chk("lit_sh_mask", {28'd0, obs_mask}, 32'h3);

      // lui x5,0x12345
      do_instr(32'h1234_52B7, 0, 1'b0);
      chk("lit_lui_imm", imm_a, 32'h1234_5000);
      chk("lit_lui_rw",  {31'd0, obs_rw}, 32'd1);

      // addi x0,x0,0 and sub x0,x1,x2: no register write, PC still advances
      t0 = int'(addr_a);
      do_instr(32'h0000_0013, 0, 1'b0);
      chk("lit_nop_rw",  {31'd0, obs_rw}, 32'd0);
      chk("lit_nop_pc",  addr_a, 32'(t0 + 4));
      do_instr(32'h4020_8033, 1, 1'b0);
      chk("lit_sub_x0_rw", {31'd0, obs_rw}, 32'd0);

      // jal -> HALT
      do_instr(32'h0000_006F, 0, 1'b0);
      chk("lit_jal_ill", {31'd0, ill_a}, 32'd1);
      chk("lit_jal_req", {31'd0, req_a}, 32'd0);

      // reset during EXECUTE
      do_reset(2);
      do_instr(32'hFFF0_0093, 0, 1'b1);
      chk("lit_rst_exec_rw", {31'd0, obs_rw}, 32'd0);
      chk("lit_rst_exec_addr", addr_a, 32'h100);
      do_instr(32'h0020_81B3, 1, 1'b0);

      // store with func3=011 is illegal
      do_reset(1);
      do_instr(32'h0011_3023, 0, 1'b0);
      chk("lit_sd_ill", {31'd0, ill_a}, 32'd1);

      // compressed-style low bits are illegal
      do_reset(1);
      do_instr(32'h0020_81B1, 0, 1'b0);
      chk("lit_lowbits_ill", {31'd0, ill_a}, 32'd1);

      // recovery after halt
      do_reset(2);
      do_instr(32'h0010_0113, 0, 1'b0);
      chk("lit_recover_ill", {31'd0, ill_a}, 32'd0);
      chk("lit_recover_rw",  {31'd0, obs_rw}, 32'd1);

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
